// File: rtl/trigger_capture_pkg.sv
// Shared sizing, sample type and state encodings for the trigger-capture block.
// Both the capture stage and its hand-off interface import this package.

package trigger_capture_pkg;

   localparam int DEPTH = 512;
   localparam int WIDTH = 12;
   localparam int PTR_W = $clog2(DEPTH);

   typedef logic [WIDTH-1:0] sample_t;
   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_TRIG,
      POST,
      UNROLL,
      HANDOFF
   } state_e;

   // HANDOFF is split into a request, then waiting for ready to fall and rise again
   typedef enum logic [1:0] {
      HS_REQ,
      HS_WAIT_FALL,
      HS_WAIT_RISE
   } hsPhase_e;

endpackage

// File: rtl/trigger_capture_if.sv
// Sample stream in, linear frame and hand-off handshake out.
// The capture block is the master; the frame-latch stage (or a bench) is the slave.

interface trigger_capture_if;
   import trigger_capture_pkg::*;

   sample_t adcData;
   logic    adcValid;
   logic    ready;
   logic    read;
   sample_t data [DEPTH];
   logic    triggered;
   logic    forced;

   modport master (
      input  adcData, adcValid, ready,
      output read, data, triggered, forced
   );

   modport slave (
      output adcData, adcValid, ready,
      input  read, data, triggered, forced
   );

endinterface

// File: rtl/trigger_capture_detect.sv
// Level/slope crossing detector: compares the incoming sample against the
// previously captured one and flags a one-cycle hit.

module trig_detect
   import trigger_capture_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  sample_t sample_i,
   input  logic    valid_i,
   input  logic    update_i,
   input  logic    slope_i,
   input  sample_t level_i,
   output logic    hit_o
);

   sample_t prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else if (update_i) begin
         prev_q <= sample_i;
      end
   end

   // Equality with the level counts as a crossing in both directions
   always_comb begin
      hit_o = 1'b0;
      if (valid_i) begin
         if (!slope_i) begin
            hit_o = (prev_q < level_i) && (sample_i >= level_i);
         end else begin
            hit_o = (prev_q > level_i) && (sample_i <= level_i);
         end
      end
   end

endmodule

// File: rtl/trigger_capture.sv
// Circular-buffer ADC capture with level/slope trigger, ring-to-frame unroll
// and a read/ready hand-off to the frame-latch stage.

module trigger_capture
   import trigger_capture_pkg::*;
#(
   parameter int PRETRIG = 128,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    run_i,
   input  logic    autoMode_i,
   input  logic    slope_i,
   input  sample_t trigLevel_i,
   trigger_capture_if.master cap
);

   localparam ptr_t             PRE_CNT    = ptr_t'(PRETRIG);
   localparam ptr_t             LAST_IDX   = ptr_t'(DEPTH - 1);
   localparam logic [PTR_W:0]   POST_LEN   = (PTR_W + 1)'(DEPTH - PRETRIG);
   localparam logic [31:0]      TOUT_LAST  = 32'(TIMEOUT - 1);
   localparam bit               SHORT_POST = ((DEPTH - PRETRIG) == 1);

   state_e         state_q, state_d;
   hsPhase_e       hsPhase_q, hsPhase_d;
   ptr_t           wrPtr_q, wrPtr_d;
   ptr_t           trigPtr_q, trigPtr_d;
   ptr_t           fillCnt_q, fillCnt_d;
   ptr_t           unrollIdx_q, unrollIdx_d;
   logic [PTR_W:0] postCnt_q, postCnt_d;
   logic [31:0]    toutCnt_q, toutCnt_d;
   logic           triggered_q, triggered_d;
   logic           forced_q, forced_d;
   logic           pendingTrig_q, pendingTrig_d;
   logic           read_q, read_d;

   sample_t        ring [DEPTH];
   sample_t        data_q [DEPTH];
   logic           capturing;
   logic           sampleWr;
   logic           trigHit;
   ptr_t           rdAddr;

   assign capturing = (state_q == ARM) || (state_q == WAIT_TRIG) || (state_q == POST);
   assign sampleWr  = capturing && cap.adcValid;
   assign rdAddr    = trigPtr_q - PRE_CNT + unrollIdx_q;

   trig_detect u_detect (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_i (cap.adcData),
      .valid_i  (cap.adcValid),
      .update_i (sampleWr),
      .slope_i  (slope_i),
      .level_i  (trigLevel_i),
      .hit_o    (trigHit)
   );

   always_comb begin
      state_d       = state_q;
      hsPhase_d     = hsPhase_q;
      wrPtr_d       = sampleWr ? wrPtr_q + ptr_t'(1) : wrPtr_q;
      trigPtr_d     = trigPtr_q;
      fillCnt_d     = fillCnt_q;
      unrollIdx_d   = unrollIdx_q;
      postCnt_d     = postCnt_q;
      toutCnt_d     = toutCnt_q;
      triggered_d   = triggered_q;
      forced_d      = forced_q;
      pendingTrig_d = pendingTrig_q;
      read_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (run_i) state_d = ARM;
         end
         ARM: begin
            if (!run_i) begin
               state_d = IDLE;
            end else if (cap.adcValid) begin
               fillCnt_d = fillCnt_q + ptr_t'(1);
               if (fillCnt_q + ptr_t'(1) == PRE_CNT) begin
                  state_d   = WAIT_TRIG;
                  toutCnt_d = '0;
               end
            end
         end
         WAIT_TRIG: begin
            if (!run_i) begin
               state_d = IDLE;
            end else begin
               if (toutCnt_q != TOUT_LAST) toutCnt_d = toutCnt_q + 32'd1;
               // A real crossing wins over a simultaneous timeout
               if (trigHit) begin
                  trigPtr_d     = wrPtr_q;
                  triggered_d   = 1'b1;
                  pendingTrig_d = 1'b0;
                  postCnt_d     = (PTR_W + 1)'(1);
                  unrollIdx_d   = '0;
                  state_d       = SHORT_POST ? UNROLL : POST;
               end else if (autoMode_i && (toutCnt_q == TOUT_LAST)) begin
                  triggered_d   = 1'b1;
                  forced_d      = 1'b1;
                  pendingTrig_d = 1'b1;
                  postCnt_d     = '0;
                  state_d       = POST;
               end
            end
         end
         POST: begin
            if (!run_i) begin
               state_d = IDLE;
            end else if (cap.adcValid) begin
               postCnt_d = postCnt_q + (PTR_W + 1)'(1);
               if (pendingTrig_q) begin
                  trigPtr_d     = wrPtr_q;
                  pendingTrig_d = 1'b0;
               end
               if (postCnt_q + (PTR_W + 1)'(1) == POST_LEN) begin
                  state_d     = UNROLL;
                  unrollIdx_d = '0;
               end
            end
         end
         UNROLL: begin
            unrollIdx_d = unrollIdx_q + ptr_t'(1);
            if (unrollIdx_q == LAST_IDX) begin
               state_d   = HANDOFF;
               hsPhase_d = HS_REQ;
            end
         end
         HANDOFF: begin
            case (hsPhase_q)
               HS_REQ: begin
                  if (cap.ready) begin
                     read_d    = 1'b1;
                     hsPhase_d = HS_WAIT_FALL;
                  end
               end
               HS_WAIT_FALL: begin
                  if (!cap.ready) hsPhase_d = HS_WAIT_RISE;
               end
               HS_WAIT_RISE: begin
                  if (cap.ready) state_d = run_i ? ARM : IDLE;
               end
               default: hsPhase_d = HS_REQ;
            endcase
         end
         default: state_d = IDLE;
      endcase

      // Every way into ARM starts a fresh acquisition
      if ((state_d == ARM) && (state_q != ARM)) begin
         fillCnt_d   = '0;
         triggered_d = 1'b0;
         forced_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         hsPhase_q     <= HS_REQ;
         wrPtr_q       <= '0;
         trigPtr_q     <= '0;
         fillCnt_q     <= '0;
         unrollIdx_q   <= '0;
         postCnt_q     <= '0;
         toutCnt_q     <= '0;
         triggered_q   <= 1'b0;
         forced_q      <= 1'b0;
         pendingTrig_q <= 1'b0;
         read_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hsPhase_q     <= hsPhase_d;
         wrPtr_q       <= wrPtr_d;
         trigPtr_q     <= trigPtr_d;
         fillCnt_q     <= fillCnt_d;
         unrollIdx_q   <= unrollIdx_d;
         postCnt_q     <= postCnt_d;
         toutCnt_q     <= toutCnt_d;
         triggered_q   <= triggered_d;
         forced_q      <= forced_d;
         pendingTrig_q <= pendingTrig_d;
         read_q        <= read_d;
      end
   end

   always_ff @(posedge clk) begin
      if (sampleWr) ring[wrPtr_q] <= cap.adcData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else if (state_q == UNROLL) begin
         data_q[unrollIdx_q] <= ring[rdAddr];
      end
   end

   assign cap.read      = read_q;
   assign cap.triggered = triggered_q;
   assign cap.forced    = forced_q;
   assign cap.data      = data_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: a list-based model predicts each frame
// when the stimulus is built, and the frame is checked when read pulses.

module tb_trigger_capture;
   import trigger_capture_pkg::*;

   localparam int PRE     = 128;
   localparam int TOUT    = 1000;
   localparam int POSTLEN = DEPTH - PRE;

   logic    clk = 1'b0;
   logic    rst_n = 1'b0;
   logic    run = 1'b0;
   logic    autoMode = 1'b0;
   logic    slope = 1'b0;
   sample_t trigLevel = '0;

   trigger_capture_if capIf();

   trigger_capture #(.PRETRIG(PRE), .TIMEOUT(TOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (run),
      .autoMode_i  (autoMode),
      .slope_i     (slope),
      .trigLevel_i (trigLevel),
      .cap         (capIf.master)
   );

   always #5 clk = ~clk;

   int      testsRun = 0;
   int      testsFailed = 0;
   int      needCount = 0;
   sample_t stim[$];
   sample_t expFrame[$];
   logic    expTrig[$];
   logic    expForced[$];
   sample_t lastFrame [DEPTH];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int frameErrors();
      int n = 0;
      for (int k = 0; k < DEPTH; k++) if (capIf.data[k] !== lastFrame[k]) n++;
      return n;
   endfunction

   function automatic int nonZeroCount();
      int n = 0;
      for (int k = 0; k < DEPTH; k++) if (capIf.data[k] != '0) n++;
      return n;
   endfunction

   // Find the trigger in the stimulus list and push the frame around it
   task automatic applyStimulus(input sample_t level, input logic slp, input logic forcedCase);
      int      t = -1;
      sample_t prev;
      if (forcedCase) begin
         for (int k = 0; k < DEPTH; k++) expFrame.push_back(stim[0]);
         needCount = stim.size();
      end else begin
         prev = stim[PRE-1];
         for (int i = PRE; i < stim.size() && t < 0; i++) begin
            if (slp ? (prev > level && stim[i] <= level) : (prev < level && stim[i] >= level)) t = i;
            prev = stim[i];
         end
         if (t < 0 || t + POSTLEN > stim.size()) begin
            $display("[TB] FAIL model: stimulus has no complete trigger window");
            $fatal(1, "[TB] bad stimulus");
         end
         for (int k = 0; k < DEPTH; k++) expFrame.push_back(stim[t-PRE+k]);
         needCount = t + POSTLEN;
      end
      expTrig.push_back(1'b1);
      expForced.push_back(forcedCase);
   endtask

   task automatic runCapture(input int validEvery, input int readyLowExtra);
      int idx = 0;
      int cyc = 0;
      int afterFed = 0;
      bit gotRead = 0;
      bit busyRead = 0;
      capIf.ready = (readyLowExtra < 0);
      run = 1'b1;
      while (!gotRead && cyc < 20000) begin
         @(negedge clk);
         if (capIf.read) begin
            gotRead  = 1;
            busyRead = !capIf.ready;
         end else begin
            if ((cyc % validEvery) == 0 && idx < stim.size()) begin
               capIf.adcData  = stim[idx];
               capIf.adcValid = 1'b1;
               idx++;
            end else begin
               capIf.adcValid = 1'b0;
            end
            if (readyLowExtra >= 0) begin
               if (idx >= needCount) afterFed++;
               capIf.ready = (afterFed > DEPTH + readyLowExtra);
            end
            cyc++;
         end
      end
      capIf.adcValid = 1'b0;
      run = 1'b0;
      checkOutput("readSeen", 32'(gotRead), 32'd1);
      checkOutput("noReadWhileBusy", 32'(busyRead), 32'd0);
      for (int k = 0; k < DEPTH; k++) lastFrame[k] = expFrame.pop_front();
      checkOutput("frameAtRead", 32'(frameErrors()), 32'd0);
      checkOutput("triggered", 32'(capIf.triggered), 32'(expTrig.pop_front()));
      checkOutput("forced", 32'(capIf.forced), 32'(expForced.pop_front()));
      @(negedge clk);
      checkOutput("readOneCycle", 32'(capIf.read), 32'd0);
      repeat (4) @(negedge clk);
      capIf.ready = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("frameReadyLow", 32'(frameErrors()), 32'd0);
      capIf.ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idleAfterHandoff", 32'(dut.state_q), 32'(IDLE));
      checkOutput("frameAfterHandoff", 32'(frameErrors()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int reads;
      capIf.adcData  = '0;
      capIf.adcValid = 1'b0;
      capIf.ready    = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("resetRead", 32'(capIf.read), 32'd0);
      checkOutput("resetTriggered", 32'(capIf.triggered), 32'd0);
      checkOutput("resetForced", 32'(capIf.forced), 32'd0);
      checkOutput("resetData", 32'(nonZeroCount()), 32'd0);
      checkOutput("resetState", 32'(dut.state_q), 32'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // Rising ramp crossing 2048
      stim.delete();
      for (int n = 0; n < 700; n++) stim.push_back(sample_t'((n * 16) % 4096));
      trigLevel = 12'd2048; slope = 1'b0; autoMode = 1'b0;
      applyStimulus(trigLevel, slope, 1'b0);
      runCapture(1, -1);
      checkOutput("rampData128", 32'(capIf.data[128]), 32'd2048);
      checkOutput("rampData127", 32'(capIf.data[127]), 32'd2032);
      checkOutput("rampData0", 32'(capIf.data[0]), 32'd0);
      checkOutput("rampData511", 32'(capIf.data[511]), 32'd4080);

      // Flat input, auto mode forces a trigger
      stim.delete();
      for (int n = 0; n < 1700; n++) stim.push_back(sample_t'(100));
      autoMode = 1'b1;
      applyStimulus(trigLevel, slope, 1'b1);
      runCapture(1, -1);
      checkOutput("forcedData200", 32'(capIf.data[200]), 32'd100);

      // Flat input without auto mode never reads; then abort from WAIT_TRIG
      autoMode = 1'b0;
      run = 1'b1;
      reads = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         capIf.adcData  = sample_t'(100);
         capIf.adcValid = 1'b1;
         if (capIf.read) reads++;
      end
      checkOutput("noAutoNoRead", 32'(reads), 32'd0);
      checkOutput("stuckInWait", 32'(dut.state_q), 32'(WAIT_TRIG));
      checkOutput("armClearsTriggered", 32'(capIf.triggered), 32'd0);
      run = 1'b0;
      capIf.adcValid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("abortToIdle", 32'(dut.state_q), 32'(IDLE));
      checkOutput("abortKeepsFrame", 32'(frameErrors()), 32'd0);

      // Falling sine through 1000, sparse valid, ready held low into HANDOFF
      stim.delete();
      for (int n = 0; n < 1400; n++)
         stim.push_back(sample_t'($rtoi(2048.0 + 1800.0 * $sin(2.0 * 3.14159265 * n / 160.0))));
      trigLevel = 12'd1000; slope = 1'b1;
      applyStimulus(trigLevel, slope, 1'b0);
      runCapture(3, 60);
      checkOutput("sineTrigAtOrBelow", 32'(capIf.data[128] <= 12'd1000), 32'd1);
      checkOutput("sinePrevAbove", 32'(capIf.data[127] > 12'd1000), 32'd1);

      // Reset in the middle of POST
      stim.delete();
      for (int n = 0; n < 700; n++) stim.push_back(sample_t'((n * 16) % 4096));
      trigLevel = 12'd2048; slope = 1'b0;
      run = 1'b1;
      @(negedge clk);
      for (int n = 0; n < PRE + 101; n++) begin
         capIf.adcData  = stim[n];
         capIf.adcValid = 1'b1;
         @(negedge clk);
      end
      capIf.adcValid = 1'b0;
      checkOutput("inPostBeforeReset", 32'(dut.state_q), 32'(POST));
      rst_n = 1'b0;
      #1;
      checkOutput("midResetRead", 32'(capIf.read), 32'd0);
      checkOutput("midResetState", 32'(dut.state_q), 32'(IDLE));
      checkOutput("midResetData", 32'(nonZeroCount()), 32'd0);
      checkOutput("midResetTriggered", 32'(capIf.triggered), 32'd0);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(trigLevel, slope, 1'b0);
      runCapture(1, -1);
      checkOutput("recaptureData128", 32'(capIf.data[128]), 32'd2048);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
